mips_ni_bridge: RTL and testbench



---
 rtl/mips_ni_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_ni_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ni_bridge.sv
// Network-interface bridge between one MIPS core and its NoC router local port.
// TX: circular queue of core send requests, each sent as a head/tail flit pair.
// RX: reassembles head/tail packets and holds the payload until the core acks.
// Optional build macro SELF_LOOPBACK_EN: self-addressed entries bypass the
// router and are loaded straight into the RX holding register.
module mips_ni_bridge #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 2,
  parameter int TXQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] node_id,
  input  logic              core_tx_valid,
  input  logic [DATA_W-1:0] core_tx_data,
  input  logic [ADDR_W-1:0] core_tx_dest,
  output logic              core_tx_ready,
  output logic              rtr_tx_valid,
  output logic [DATA_W+1:0] rtr_tx_flit,
  input  logic              rtr_tx_ready,
  input  logic              rtr_rx_valid,
  input  logic [DATA_W+1:0] rtr_rx_flit,
  output logic              rtr_rx_ready,
  output logic              core_rx_valid,
  output logic [DATA_W-1:0] core_rx_data,
  output logic [ADDR_W-1:0] core_rx_src,
  input  logic              core_rx_ack,
  output logic              proto_err
);

  localparam int PW   = $clog2(TXQ_DEPTH);
  localparam int CW   = PW + 1;
  localparam int PADW = DATA_W - 2 * ADDR_W;

  localparam logic [1:0] TY_HEAD = 2'b01;
  localparam logic [1:0] TY_TAIL = 2'b10;

  typedef enum logic [1:0] {
    T_IDLE, T_HEAD, T_TAIL
`ifdef SELF_LOOPBACK_EN
    , T_LOOP
`endif
  } tx_state_t;

  typedef enum logic [1:0] {R_IDLE, R_BODY, R_HOLD} rx_state_t;

  logic [DATA_W-1:0] r_q_data [TXQ_DEPTH];
  logic [ADDR_W-1:0] r_q_dest [TXQ_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic              r_tx_rdy;
  logic              w_push, w_pop, w_more, w_loop_take;

  tx_state_t         r_tx_state, w_tx_nxt;
  logic              w_tx_valid;
  logic [DATA_W+1:0] w_tx_flit;

  rx_state_t         r_rx_state, w_rx_nxt;
  logic [1:0]        w_rx_type;
  logic              w_rx_acc, w_rx_err, w_cap_src, w_deliver;
  logic [ADDR_W-1:0] r_src_cap, r_rx_src;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_err;

  assign w_push = core_tx_valid && core_tx_ready;
  // Entries left after the current pop, counting a push in the same cycle.
  assign w_more = (r_count != CW'(1)) || w_push;

  // Queue occupancy for the next cycle.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // TX queue storage, pointers, count and registered not-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tx_rdy <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_data[r_wr_ptr] <= core_tx_data;
        r_q_dest[r_wr_ptr] <= core_tx_dest;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= w_count_nxt;
      r_tx_rdy <= (w_count_nxt != CW'(TXQ_DEPTH));
    end
  end

`ifdef SELF_LOOPBACK_EN
  logic w_head_self, w_next_self;
  assign w_head_self = (r_q_dest[r_rd_ptr] == node_id);
  // The entry after the one being popped is either already queued or is the
  // one being pushed this very cycle (not yet visible in storage).
  assign w_next_self = (r_count > CW'(1)) ? (r_q_dest[r_rd_ptr + PW'(1)] == node_id)
                                          : (core_tx_dest == node_id);
`endif

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= T_IDLE;
    else     r_tx_state <= w_tx_nxt;
  end

  // TX next-state, flit formatting and pop generation.
  always_comb begin
    w_tx_nxt    = r_tx_state;
    w_tx_valid  = 1'b0;
    w_tx_flit   = '0;
    w_pop       = 1'b0;
    w_loop_take = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (r_count != '0) begin
`ifdef SELF_LOOPBACK_EN
          w_tx_nxt = w_head_self ? T_LOOP : T_HEAD;
`else
          w_tx_nxt = T_HEAD;
`endif
        end
      end
      T_HEAD: begin
        w_tx_valid = 1'b1;
        w_tx_flit  = {TY_HEAD, r_q_dest[r_rd_ptr], node_id, {PADW{1'b0}}};
        if (rtr_tx_ready) w_tx_nxt = T_TAIL;
      end
      T_TAIL: begin
        w_tx_valid = 1'b1;
        w_tx_flit  = {TY_TAIL, r_q_data[r_rd_ptr]};
        if (rtr_tx_ready) begin
          w_pop = 1'b1;
`ifdef SELF_LOOPBACK_EN
          w_tx_nxt = w_more ? (w_next_self ? T_LOOP : T_HEAD) : T_IDLE;
`else
          w_tx_nxt = w_more ? T_HEAD : T_IDLE;
`endif
        end
      end
`ifdef SELF_LOOPBACK_EN
      T_LOOP: begin
        if (r_rx_state == R_IDLE) begin
          w_loop_take = 1'b1;
          w_pop       = 1'b1;
          w_tx_nxt    = T_IDLE;
        end
      end
`endif
      default: w_tx_nxt = T_IDLE;
    endcase
  end

  assign core_tx_ready = r_tx_rdy && !rst;
  assign rtr_tx_valid  = w_tx_valid && !rst;
  assign rtr_tx_flit   = rst ? '0 : w_tx_flit;

  assign w_rx_type    = rtr_rx_flit[DATA_W+1:DATA_W];
  assign rtr_rx_ready = !rst && (r_rx_state != R_HOLD) && !w_loop_take;
  assign w_rx_acc     = rtr_rx_valid && rtr_rx_ready;

  // RX next-state and protocol-error detection.
  always_comb begin
    w_rx_nxt  = r_rx_state;
    w_rx_err  = 1'b0;
    w_cap_src = 1'b0;
    w_deliver = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        if (w_rx_acc) begin
          if (w_rx_type == TY_HEAD) begin
            w_cap_src = 1'b1;
            w_rx_nxt  = R_BODY;
          end else begin
            w_rx_err = 1'b1;
          end
        end
      end
      R_BODY: begin
        if (w_rx_acc) begin
          if (w_rx_type == TY_TAIL) begin
            w_deliver = 1'b1;
            w_rx_nxt  = R_HOLD;
          end else if (w_rx_type == TY_HEAD) begin
            w_cap_src = 1'b1;
            w_rx_err  = 1'b1;
          end else begin
            w_rx_err = 1'b1;
          end
        end
      end
      R_HOLD: begin
        if (core_rx_ack) w_rx_nxt = R_IDLE;
      end
      default: w_rx_nxt = R_IDLE;
    endcase
  end

  // RX state, captured source, held payload and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= R_IDLE;
      r_src_cap  <= '0;
      r_rx_src   <= '0;
      r_rx_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rx_state <= w_rx_nxt;
      r_err      <= w_rx_err;
      if (w_cap_src) r_src_cap <= rtr_rx_flit[DATA_W-ADDR_W-1 -: ADDR_W];
      if (w_deliver) begin
        r_rx_data <= rtr_rx_flit[DATA_W-1:0];
        r_rx_src  <= r_src_cap;
      end
      // Loopback only fires in R_IDLE with the router port blocked, so it
      // never collides with a delivery from the router.
      if (w_loop_take) begin
        r_rx_state <= R_HOLD;
        r_rx_data  <= r_q_data[r_rd_ptr];
        r_rx_src   <= node_id;
      end
    end
  end

  assign core_rx_valid = (r_rx_state == R_HOLD) && !rst;
  assign core_rx_data  = rst ? '0 : r_rx_data;
  assign core_rx_src   = rst ? '0 : r_rx_src;
  assign proto_err     = r_err && !rst;

endmodule

// File: tb/tb_mips_ni_bridge.sv
// Directed bench for mips_ni_bridge with scoreboards for router-bound flits
// and core-bound payloads; follows SELF_LOOPBACK_EN when it is defined.
module tb_mips_ni_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  node_id;
  logic        core_tx_valid;
  logic [31:0] core_tx_data;
  logic [1:0]  core_tx_dest;
  logic        core_tx_ready;
  logic        rtr_tx_valid;
  logic [33:0] rtr_tx_flit;
  logic        rtr_tx_ready;
  logic        rtr_rx_valid;
  logic [33:0] rtr_rx_flit;
  logic        rtr_rx_ready;
  logic        core_rx_valid;
  logic [31:0] core_rx_data;
  logic [1:0]  core_rx_src;
  logic        core_rx_ack;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [33:0] txq[$];
  logic [33:0] rxq[$];
  int          flit_cyc[$];
  logic        rx_prev = 1'b0;

  mips_ni_bridge #(.DATA_W(32), .ADDR_W(2), .TXQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .node_id(node_id),
    .core_tx_valid(core_tx_valid), .core_tx_data(core_tx_data),
    .core_tx_dest(core_tx_dest), .core_tx_ready(core_tx_ready),
    .rtr_tx_valid(rtr_tx_valid), .rtr_tx_flit(rtr_tx_flit),
    .rtr_tx_ready(rtr_tx_ready), .rtr_rx_valid(rtr_rx_valid),
    .rtr_rx_flit(rtr_rx_flit), .rtr_rx_ready(rtr_rx_ready),
    .core_rx_valid(core_rx_valid), .core_rx_data(core_rx_data),
    .core_rx_src(core_rx_src), .core_rx_ack(core_rx_ack),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk_head(input logic [1:0] d, input logic [1:0] s);
    return {2'b01, d, s, 28'h0};
  endfunction

  function automatic logic [33:0] mk_tail(input logic [31:0] x);
    return {2'b10, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] x, input logic [1:0] d);
    core_tx_valid = 1'b1;
    core_tx_data  = x;
    core_tx_dest  = d;
    tick();
    core_tx_valid = 1'b0;
  endtask

  task automatic wait_txq(input int maxc, input string tag);
    for (int i = 0; i < maxc && txq.size() != 0; i++) tick();
    check(tag, 64'(txq.size()), 64'd0);
  endtask

  // Flit and payload scoreboards, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && rtr_tx_valid && rtr_tx_ready) begin
      if (txq.size() == 0) check("tx_extra_flit", {30'h0, rtr_tx_flit}, 64'h0);
      else                 check("tx_flit", {30'h0, rtr_tx_flit}, {30'h0, txq.pop_front()});
      flit_cyc.push_back(cyc);
    end
    if (!rst && core_rx_valid && !rx_prev) begin
      if (rxq.size() == 0) check("rx_extra_payload", {30'h0, core_rx_src, core_rx_data}, 64'h0);
      else                 check("rx_payload", {30'h0, core_rx_src, core_rx_data}, {30'h0, rxq.pop_front()});
    end
    rx_prev = core_rx_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  dests [5];
    logic [31:0] d;
    dests = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    rst = 1'b1; node_id = 2'd1;
    core_tx_valid = 1'b0; core_tx_data = '0; core_tx_dest = '0;
    rtr_tx_ready = 1'b0; rtr_rx_valid = 1'b0; rtr_rx_flit = '0; core_rx_ack = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_tx_ready", 64'(core_tx_ready), 64'd0);
    check("rst_tx_valid", 64'(rtr_tx_valid), 64'd0);
    check("rst_rx_ready", 64'(rtr_rx_ready), 64'd0);
    check("rst_rx_valid", 64'(core_rx_valid), 64'd0);
    check("rst_err", 64'(proto_err), 64'd0);
    rst = 1'b0;
    check("rdy_same_cycle", 64'(core_tx_ready), 64'd0);
    tick();
    check("rdy_after_rst", 64'(core_tx_ready), 64'd1);

    // Single packet
    rtr_tx_ready = 1'b1;
    flit_cyc.delete();
    txq.push_back(mk_head(2'd2, 2'd1));
    txq.push_back(mk_tail(32'hDEADBEEF));
    push_entry(32'hDEADBEEF, 2'd2);
    wait_txq(20, "pkt1_drain");
    check("pkt1_flits", 64'(flit_cyc.size()), 64'd2);
    check("pkt1_gap", (flit_cyc.size() == 2) ? 64'(flit_cyc[1] - flit_cyc[0]) : 64'hFFFF, 64'd1);
    tick();
    check("pkt1_idle", 64'(rtr_tx_valid), 64'd0);
    check("pkt1_rdy", 64'(core_tx_ready), 64'd1);

    // Fill queue while router stalls, fifth push refused
    rtr_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = $urandom();
      core_tx_valid = 1'b1; core_tx_data = d; core_tx_dest = dests[i];
      check($sformatf("fill_rdy_%0d", i), 64'(core_tx_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) begin
        txq.push_back(mk_head(dests[i], 2'd1));
        txq.push_back(mk_tail(d));
      end
      tick();
    end
    core_tx_valid = 1'b0;
    check("full_rdy", 64'(core_tx_ready), 64'd0);
    flit_cyc.delete();
    rtr_tx_ready = 1'b1;
    wait_txq(30, "burst_drain");
    check("burst_flits", 64'(flit_cyc.size()), 64'd8);
    check("burst_span", (flit_cyc.size() == 8) ? 64'(flit_cyc[7] - flit_cyc[0]) : 64'hFFFF, 64'd7);
    rtr_tx_ready = 1'b0;
    tick();

    // RX normal packet
    check("rx_rdy_idle", 64'(rtr_rx_ready), 64'd1);
    rtr_rx_valid = 1'b1; rtr_rx_flit = mk_head(2'd1, 2'd3);
    tick();
    rtr_rx_flit = mk_tail(32'h12345678);
    rxq.push_back({2'd3, 32'h12345678});
    tick();
    rtr_rx_valid = 1'b0;
    check("rx_valid", 64'(core_rx_valid), 64'd1);
    check("rx_src", 64'(core_rx_src), 64'd3);
    check("rx_data", 64'(core_rx_data), 64'h12345678);
    check("rx_rdy_hold", 64'(rtr_rx_ready), 64'd0);
    repeat (3) tick();
    check("rx_hold", 64'(core_rx_valid), 64'd1);
    core_rx_ack = 1'b1; tick(); core_rx_ack = 1'b0;
    check("rx_acked", 64'(core_rx_valid), 64'd0);
    check("rx_rdy_back", 64'(rtr_rx_ready), 64'd1);

    // Tail in idle
    rtr_rx_valid = 1'b1; rtr_rx_flit = mk_tail(32'h55);
    tick();
    rtr_rx_valid = 1'b0;
    check("idle_tail_err", 64'(proto_err), 64'd1);
    check("idle_tail_valid", 64'(core_rx_valid), 64'd0);
    tick();
    check("idle_tail_err_end", 64'(proto_err), 64'd0);

    // Head, head, tail
    rtr_rx_valid = 1'b1; rtr_rx_flit = mk_head(2'd1, 2'd1);
    tick();
    check("hh_first_err", 64'(proto_err), 64'd0);
    rtr_rx_flit = mk_head(2'd1, 2'd2);
    tick();
    check("hh_second_err", 64'(proto_err), 64'd1);
    rtr_rx_flit = mk_tail(32'hA5A55A5A);
    rxq.push_back({2'd2, 32'hA5A55A5A});
    tick();
    rtr_rx_valid = 1'b0;
    check("hh_tail_err", 64'(proto_err), 64'd0);
    check("hh_src", 64'(core_rx_src), 64'd2);
    core_rx_ack = 1'b1; tick(); core_rx_ack = 1'b0;

    // Illegal type inside a packet
    rtr_rx_valid = 1'b1; rtr_rx_flit = mk_head(2'd1, 2'd3);
    tick();
    rtr_rx_flit = {2'b11, 32'h0BAD0BAD};
    tick();
    check("ill_err", 64'(proto_err), 64'd1);
    check("ill_valid", 64'(core_rx_valid), 64'd0);
    rtr_rx_flit = mk_tail(32'h0000BEEF);
    rxq.push_back({2'd3, 32'h0000BEEF});
    tick();
    rtr_rx_valid = 1'b0;
    check("ill_deliver", 64'(core_rx_valid), 64'd1);
    core_rx_ack = 1'b1; tick(); core_rx_ack = 1'b0;

    // Reset during tail with two entries queued
    push_entry(32'h00000111, 2'd0);
    push_entry(32'h00000222, 2'd2);
    check("rt_head_valid", 64'(rtr_tx_valid), 64'd1);
    txq.push_back(mk_head(2'd0, 2'd1));
    rtr_tx_ready = 1'b1; tick(); rtr_tx_ready = 1'b0;
    check("rt_tail_flit", {30'h0, rtr_tx_flit}, {30'h0, mk_tail(32'h00000111)});
    rst = 1'b1;
    tick();
    check("rt_valid_rst", 64'(rtr_tx_valid), 64'd0);
    check("rt_rdy_rst", 64'(core_tx_ready), 64'd0);
    rst = 1'b0;
    check("rt_rdy_fall", 64'(core_tx_ready), 64'd0);
    tick();
    check("rt_rdy_rise", 64'(core_tx_ready), 64'd1);
    repeat (3) tick();
    check("rt_queue_empty", 64'(rtr_tx_valid), 64'd0);

    // Self-addressed entry
    rtr_tx_ready = 1'b1;
`ifdef SELF_LOOPBACK_EN
    rxq.push_back({2'd1, 32'hCAFEF00D});
    push_entry(32'hCAFEF00D, 2'd1);
    for (int i = 0; i < 10 && !core_rx_valid; i++) tick();
    check("loop_valid", 64'(core_rx_valid), 64'd1);
    check("loop_src", 64'(core_rx_src), 64'd1);
    check("loop_no_flit", 64'(rtr_tx_valid), 64'd0);
    core_rx_ack = 1'b1; tick(); core_rx_ack = 1'b0;
`else
    txq.push_back(mk_head(2'd1, 2'd1));
    txq.push_back(mk_tail(32'hCAFEF00D));
    push_entry(32'hCAFEF00D, 2'd1);
    wait_txq(20, "self_drain");
    check("self_no_rx", 64'(core_rx_valid), 64'd0);
`endif
    tick();
    check("rxq_empty", 64'(rxq.size()), 64'd0);
    check("txq_empty", 64'(txq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
